// File: rtl/imm_rot_encoder.sv
// Rotated-immediate encoder: searches the 16 even rotations of a 32-bit constant, one per clock,
// for the smallest rotation whose result fits in 8 bits. Optional MVN-form second pass: INV_SEARCH_EN.
module imm_rot_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        fits,
  output logic [11:0] imm12,
  output logic        inv
);

  // state  | meaning
  // IDLE   | waiting for start; result outputs hold the last encoding
  // SEARCH | testing one rotation of val_q per cycle
  // DONE   | one-cycle done pulse, result valid
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [3:0]  rot_q, rot_d;
  logic        fits_q, fits_d;
  logic [11:0] imm12_q, imm12_d;

  logic [4:0]  shamt;
  logic [63:0] dbl;
  logic [31:0] cand;
  logic        hit;

`ifdef INV_SEARCH_EN
  logic        phase_q, phase_d;
  logic        inv_q, inv_d;
`endif

  // Left-rotate by 2*rot: the high half of the doubled word shifted left.
  assign shamt = {rot_q, 1'b0};
  assign dbl   = {val_q, val_q} << shamt;
  assign cand  = dbl[63:32];
  assign hit   = (cand[31:8] == 24'd0);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rot_d   = rot_q;
    fits_d  = fits_q;
    imm12_d = imm12_q;
`ifdef INV_SEARCH_EN
    phase_d = phase_q;
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          rot_d   = 4'd0;
          fits_d  = 1'b0;
          imm12_d = 12'd0;
`ifdef INV_SEARCH_EN
          phase_d = 1'b0;
          inv_d   = 1'b0;
`endif
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          fits_d  = 1'b1;
          imm12_d = {rot_q, cand[7:0]};
`ifdef INV_SEARCH_EN
          inv_d   = phase_q;
`endif
          state_d = DONE;
        end else if (rot_q != 4'd15) begin
          rot_d = rot_q + 4'd1;
        end else begin
`ifdef INV_SEARCH_EN
          if (!phase_q) begin
            val_d   = ~val_q;
            phase_d = 1'b1;
            rot_d   = 4'd0;
          end else begin
            fits_d  = 1'b0;
            imm12_d = 12'd0;
            inv_d   = 1'b0;
            state_d = DONE;
          end
`else
          fits_d  = 1'b0;
          imm12_d = 12'd0;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      val_q   <= 32'd0;
      rot_q   <= 4'd0;
      fits_q  <= 1'b0;
      imm12_q <= 12'd0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rot_q   <= rot_d;
      fits_q  <= fits_d;
      imm12_q <= imm12_d;
    end
  end

`ifdef INV_SEARCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      inv_q   <= inv_d;
    end
  end
  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  assign busy  = (state_q == SEARCH) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign fits  = fits_q;
  assign imm12 = imm12_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Directed bench for imm_rot_encoder: vector table plus hand sequences for
// ignored starts, start during DONE and reset mid-search.
module tb_imm_rot_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] value;
  logic        busy, done, fits, inv;
  logic [11:0] imm12;

  int n_cmp = 0;
  int n_err = 0;

  imm_rot_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .fits    (fits),
    .imm12   (imm12),
    .inv     (inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          lat;
    logic        fits;
    logic [11:0] imm;
    logic        inv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Accept occurs at the posedge following this call; returns at the negedge after it.
  task automatic issue(input logic [31:0] v);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("fits_cleared", {31'd0, fits}, 32'd0);
    chk("imm_cleared", {20'd0, imm12}, 32'd0);
  endtask

  // Counts edges until done; optionally re-pulses start (value=1) at the negedge where lat==pulse_at.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == pulse_at) begin
        value = 32'h1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  task automatic check_result(input string nm, input vec_t e, input int lat);
    chk({nm, "_lat"},  lat, e.lat);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, "_fits"}, {31'd0, fits}, {31'd0, e.fits});
    chk({nm, "_imm"},  {20'd0, imm12}, {20'd0, e.imm});
    chk({nm, "_inv"},  {31'd0, inv}, {31'd0, e.inv});
  endtask

  vec_t vecs[8];
  vec_t e;
  int   lat;

  initial begin
    vecs[0] = '{32'h000000FF, 1,  1'b1, 12'h0FF, 1'b0};
    vecs[1] = '{32'hFF000000, 5,  1'b1, 12'h4FF, 1'b0};
    vecs[2] = '{32'hF000000F, 3,  1'b1, 12'h2FF, 1'b0};
    vecs[3] = '{32'hC000003F, 2,  1'b1, 12'h1FF, 1'b0};
    vecs[4] = '{32'h000003FC, 16, 1'b1, 12'hFFF, 1'b0};
    vecs[5] = '{32'h00000000, 1,  1'b1, 12'h000, 1'b0};
`ifdef INV_SEARCH_EN
    vecs[6] = '{32'h00000101, 32, 1'b0, 12'h000, 1'b0};
    vecs[7] = '{32'hFFFFFF00, 17, 1'b1, 12'h0FF, 1'b1};
`else
    vecs[6] = '{32'h00000101, 16, 1'b0, 12'h000, 1'b0};
    vecs[7] = '{32'hFFFFFF00, 16, 1'b0, 12'h000, 1'b0};
`endif

    reset_n = 1'b0;
    start   = 1'b0;
    value   = 32'd0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fits", {31'd0, fits}, 32'd0);
    chk("rst_imm",  {20'd0, imm12}, 32'd0);
    chk("rst_inv",  {31'd0, inv}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].v);
      wait_done(-1, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_fall",      {31'd0, busy}, 32'd0);
      chk("fits_hold",      {31'd0, fits}, {31'd0, vecs[i].fits});
      chk("imm_hold",       {20'd0, imm12}, {20'd0, vecs[i].imm});
    end

    // start re-pulsed mid-search is ignored
    issue(32'hFF000000);
    wait_done(2, lat);
    e = '{32'hFF000000, 5, 1'b1, 12'h4FF, 1'b0};
    check_result("repulse", e, lat);

    // start held during the DONE cycle is ignored
    value = 32'h000000FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", {31'd0, busy}, 32'd0);
    chk("done_start_imm",  {20'd0, imm12}, 32'h4FF);
    @(negedge clk);
    chk("done_start_idle", {31'd0, busy}, 32'd0);

    // reset during search aborts with no done
    issue(32'h00000101);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_fits", {31'd0, fits}, 32'd0);
    chk("abort_imm",  {20'd0, imm12}, 32'd0);
    chk("abort_inv",  {31'd0, inv}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0) chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    issue(32'h00000000);
    wait_done(-1, lat);
    e = '{32'h0, 1, 1'b1, 12'h000, 1'b0};
    check_result("post_rst", e, lat);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
